serial_parity_word_gen: RTL and testbench
=========================================

// Module: serial_parity_word_gen
// PURPOSE
//  Parametrised serial parity generator/framer; successor to the fixed 4-bit BCD odd-parity FSM.
//  Accepts one data bit per enabled clock, frames WIDTH-bit words, emits the parity bit
//  (Mealy, during the last bit slot), and publishes the assembled word with a range check.
//  Sits between a serial input pin/shifter and downstream word-level logic.
// PARAMETERS
//  WIDTH      4   bits per word (>=2)
//  MAX_VALUE  9   largest legal word value; above this raises range_err (9 = BCD)
//  MSB_FIRST  1   1: first bit received is word MSB; 0: first bit is LSB
// PORTS
//  clock      in   1      rising-edge clock
//  reset      in   1      asynchronous, active-low reset
//  x          in   1      serial data bit
//  x_valid    in   1      x is a valid bit this cycle (0 = stall, state frozen)
//  sync_clr   in   1      synchronous framing restart (discard partial word)
//  odd_sel    in   1      1 = odd parity, 0 = even parity
//  z          out  1      parity bit, valid only in last bit slot (combinational)
//  bit_idx    out  clog2(WIDTH)  position of the next bit within the word
//  word_q     out  WIDTH  last completed word
//  word_valid out  1      one-cycle pulse: word_q/range_err updated
//  range_err  out  1      last completed word > MAX_VALUE
// BEHAVIOUR
//  - State = bit counter S0..S(WIDTH-1) (bit_idx) + running parity par + shift reg.
//  - reset=0 (any time, async): bit_idx=0, par=0, shift=0, word_q=0, word_valid=0,
//    range_err=0; partial word discarded. z=0 while reset asserted.
//  - Priority per edge: sync_clr > x_valid > hold.
//  - sync_clr=1: bit_idx=0, par=0, shift=0, word_valid=0; word_q/range_err keep value;
//    x ignored that cycle even if x_valid=1.
//  - x_valid=1, bit_idx<WIDTH-1: shift in x, par<=par^x, bit_idx++ ; word_valid<=0.
//  - x_valid=1, bit_idx==WIDTH-1: word complete; word_q<=assembled word (incl. this x),
//    range_err<=(word>MAX_VALUE), word_valid<=1 (for exactly 1 cycle), bit_idx<=0,
//    par<=0, shift<=0. Next word may start the following cycle (no gap).
//  - x_valid=0: all state held; word_valid<=0.
//  - z = x_valid & (bit_idx==WIDTH-1) & ~sync_clr & (par ^ x ^ odd_sel); 0 otherwise.
//    Total ones over WIDTH data bits + z is odd when odd_sel=1, even when odd_sel=0.
//  - odd_sel only matters in the last slot; may change between words freely.
//  - Latency: z same cycle as last bit; word_q/word_valid/range_err one clock after it.
//  - MSB_FIRST=1: shift left, x into bit0; MSB_FIRST=0: shift right, x into bit WIDTH-1.
//  - Comparison unsigned, WIDTH bits; MAX_VALUE >= 2^WIDTH-1 means range_err never set.
// TESTING (WIDTH=4, MAX_VALUE=9, MSB_FIRST=1 unless noted)
//  1 odd_sel=1, bits 0,0,1,1 back-to-back -> z=1 in 4th slot only; next cycle word_q=4'h3,
//    word_valid=1 for 1 cycle, range_err=0. Repeat all 16 codes: z matches odd parity,
//    range_err=1 exactly for 10..15 (e.g. 1,0,1,0 -> word_q=4'hA, z=1, range_err=1).
//  2 odd_sel=0, bits 0,1,1,1 -> z=1, word_q=4'h7; odd_sel=1 same bits -> z=0.
//  3 Stalls: 1,0,0,1 with x_valid=0 for 3 cycles between each bit -> z=1 only in 4th valid
//    slot, word_q=4'h9, single word_valid pulse, bit_idx frozen during stalls.
//  4 Reset low after 2 bits (async, mid-cycle), release, then 0,1,1,1 -> all outputs 0
//    during reset; word_q=4'h7, z=0 (odd); no stale bits. sync_clr with x_valid=1 at
//    bit 3 -> bit_idx=0, word_q unchanged, no word_valid.
//  5 MSB_FIRST=0, WIDTH=8, MAX_VALUE=255: bits 1,0,0,0,0,0,0,0 -> word_q=8'h01, z=0 odd,
//    range_err=0; 8 continuous words -> 8 pulses, one every 8 cycles.

Source files
------------

// File: rtl/serial_parity_word_gen_if.sv
`default_nettype none
// ============================================================================
// Module   : serial_parity_word_gen_if
// Purpose  : Bundles the serial-in / word-out signals of serial_parity_word_gen.
//            The master side feeds bits and framing controls; the slave side
//            (the generator) returns parity, bit position and assembled words.
// Revision : 1.0 - initial release
// ============================================================================
interface serial_parity_word_gen_if #(
  parameter int WIDTH = 4
) ();

  localparam int c_idx_w = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic               x;
  logic               x_valid;
  logic               sync_clr;
  logic               odd_sel;
  logic               z;
  logic [c_idx_w-1:0] bit_idx;
  logic [WIDTH-1:0]   word_q;
  logic               word_valid;
  logic               range_err;

  modport master (
    output x, x_valid, sync_clr, odd_sel,
    input  z, bit_idx, word_q, word_valid, range_err
  );

  modport slave (
    input  x, x_valid, sync_clr, odd_sel,
    output z, bit_idx, word_q, word_valid, range_err
  );

endinterface
`default_nettype wire

// File: rtl/serial_parity_word_gen.sv
`default_nettype none
// ============================================================================
// Module   : serial_parity_word_gen
// Purpose  : Serial parity generator / word framer. Takes one bit per enabled
//            clock, emits the parity bit during the last bit slot of each
//            WIDTH-bit word, and publishes the assembled word with an
//            over-range flag one clock later.
// Revision : 1.0 - initial release
// ============================================================================
module serial_parity_word_gen #(
  parameter int          WIDTH     = 4,
  parameter int unsigned MAX_VALUE = 9,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic                    clock,
  input  logic                    reset,
  serial_parity_word_gen_if.slave bus
);

  localparam int                 c_idx_w    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(WIDTH - 1);
  // When every WIDTH-bit value is legal the comparator is dropped entirely.
  localparam bit                 c_range_never =
    (64'(MAX_VALUE) >= ((64'd1 << WIDTH) - 64'd1));
  localparam logic [WIDTH-1:0]   c_max_word = WIDTH'(MAX_VALUE);

  logic [c_idx_w-1:0] r_bit_idx;
  logic               r_par;
  // Only WIDTH-1 earlier bits ever need to be remembered; the last bit of the
  // word comes straight from the input when the word is published.
  logic [WIDTH-2:0]   r_shift;
  logic [WIDTH-1:0]   r_word_q;
  logic               r_word_valid;
  logic               r_range_err;

  logic               w_last;
  logic               w_take;
  logic               w_over;
  logic [WIDTH-1:0]   w_word;
  logic [WIDTH-2:0]   w_next_shift;

  assign w_last = (r_bit_idx == c_last_idx);
  assign w_take = bus.x_valid & ~bus.sync_clr;

  // Word as it would look with the current bit appended, in arrival order.
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign w_word       = {r_shift, bus.x};
      assign w_next_shift = w_word[WIDTH-2:0];
    end else begin : g_lsb_first
      assign w_word       = {bus.x, r_shift};
      assign w_next_shift = w_word[WIDTH-1:1];
    end
  endgenerate

  generate
    if (c_range_never) begin : g_no_range
      assign w_over = 1'b0;
    end else begin : g_range_chk
      assign w_over = (w_word > c_max_word);
    end
  endgenerate

  // Mealy parity: valid only while the final bit of the word is on the input.
  assign bus.z = reset & w_take & w_last & (r_par ^ bus.x ^ bus.odd_sel);

  // Bit counter, running parity, shift register and word publication.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_bit_idx    <= '0;
      r_par        <= 1'b0;
      r_shift      <= '0;
      r_word_q     <= '0;
      r_word_valid <= 1'b0;
      r_range_err  <= 1'b0;
    end else if (bus.sync_clr) begin
      r_bit_idx    <= '0;
      r_par        <= 1'b0;
      r_shift      <= '0;
      r_word_valid <= 1'b0;
    end else if (bus.x_valid) begin
      if (w_last) begin
        r_word_q     <= w_word;
        r_range_err  <= w_over;
        r_word_valid <= 1'b1;
        r_bit_idx    <= '0;
        r_par        <= 1'b0;
        r_shift      <= '0;
      end else begin
        r_shift      <= w_next_shift;
        r_par        <= r_par ^ bus.x;
        r_bit_idx    <= r_bit_idx + 1'b1;
        r_word_valid <= 1'b0;
      end
    end else begin
      r_word_valid <= 1'b0;
    end
  end

  assign bus.bit_idx    = r_bit_idx;
  assign bus.word_q     = r_word_q;
  assign bus.word_valid = r_word_valid;
  assign bus.range_err  = r_range_err;

endmodule
`default_nettype wire

// File: tb/tb_serial_parity_word_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_parity_word_gen
// Purpose  : Self-checking bench. Two generators (4-bit BCD MSB-first and
//            8-bit LSB-first full-range) see the same input stream; each is
//            compared against a word-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_parity_word_gen;

  localparam int W_A   = 4;
  localparam int MAX_A = 9;
  localparam int W_B   = 8;
  localparam int MAX_B = 255;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  serial_parity_word_gen_if #(.WIDTH(W_A)) if_a ();
  serial_parity_word_gen_if #(.WIDTH(W_B)) if_b ();

  serial_parity_word_gen #(.WIDTH(W_A), .MAX_VALUE(MAX_A), .MSB_FIRST(1'b1)) dut_a (
    .clock (clk),
    .reset (rst_n),
    .bus   (if_a.slave)
  );

  serial_parity_word_gen #(.WIDTH(W_B), .MAX_VALUE(MAX_B), .MSB_FIRST(1'b0)) dut_b (
    .clock (clk),
    .reset (rst_n),
    .bus   (if_b.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: index 0 = instance A, index 1 = instance B.
  int width_m [2] = '{W_A, W_B};
  int maxv_m  [2] = '{MAX_A, MAX_B};
  bit msb_m   [2] = '{1'b1, 1'b0};
  int bits_m  [2][8];
  int cnt     [2];
  int exp_wq  [2];
  bit exp_wv  [2];
  bit exp_re  [2];
  int pulses  [2];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int ones_so_far(input int k);
    int s = 0;
    for (int i = 0; i < cnt[k]; i++) s += bits_m[k][i];
    return s;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      cnt[k] = 0; exp_wq[k] = 0; exp_wv[k] = 1'b0; exp_re[k] = 1'b0;
    end
  endtask

  task automatic drive(input bit x, input bit v, input bit c, input bit o);
    if_a.x = x; if_a.x_valid = v; if_a.sync_clr = c; if_a.odd_sel = o;
    if_b.x = x; if_b.x_valid = v; if_b.sync_clr = c; if_b.odd_sel = o;
  endtask

  task automatic check_regs();
    check_val("a_word_q", 32'(if_a.word_q), 32'(exp_wq[0]));
    check_val("a_word_valid", 32'(if_a.word_valid), 32'(exp_wv[0]));
    check_val("a_range_err", 32'(if_a.range_err), 32'(exp_re[0]));
    check_val("a_bit_idx", 32'(if_a.bit_idx), 32'(cnt[0]));
    check_val("b_word_q", 32'(if_b.word_q), 32'(exp_wq[1]));
    check_val("b_word_valid", 32'(if_b.word_valid), 32'(exp_wv[1]));
    check_val("b_range_err", 32'(if_b.range_err), 32'(exp_re[1]));
    check_val("b_bit_idx", 32'(if_b.bit_idx), 32'(cnt[1]));
  endtask

  // One clock: drive on the falling edge, check z before the rising edge,
  // advance the model, then check registered outputs just after the edge.
  task automatic cycle(input bit x, input bit v, input bit c, input bit o);
    int zexp [2];
    int w;
    @(negedge clk);
    drive(x, v, c, o);
    #1;
    for (int k = 0; k < 2; k++) begin
      zexp[k] = 0;
      if (v && !c && cnt[k] == width_m[k] - 1) zexp[k] = (ones_so_far(k) + x + o) % 2;
    end
    check_val("a_z", 32'(if_a.z), 32'(zexp[0]));
    check_val("b_z", 32'(if_b.z), 32'(zexp[1]));
    for (int k = 0; k < 2; k++) begin
      if (c) begin
        cnt[k] = 0; exp_wv[k] = 1'b0;
      end else if (v) begin
        bits_m[k][cnt[k]] = x;
        cnt[k]++;
        if (cnt[k] == width_m[k]) begin
          w = 0;
          for (int i = 0; i < width_m[k]; i++)
            w += msb_m[k] ? (bits_m[k][i] << (width_m[k] - 1 - i)) : (bits_m[k][i] << i);
          exp_wq[k] = w;
          exp_re[k] = (w > maxv_m[k]);
          exp_wv[k] = 1'b1;
          cnt[k]    = 0;
        end else begin
          exp_wv[k] = 1'b0;
        end
      end else begin
        exp_wv[k] = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    check_regs();
    if (if_a.word_valid) pulses[0]++;
    if (if_b.word_valid) pulses[1]++;
  endtask

  task automatic send_word4(input int val, input bit o);
    for (int i = W_A - 1; i >= 0; i--) cycle(bit'((val >> i) & 1), 1'b1, 1'b0, o);
  endtask

  task automatic check_reset_outputs();
    check_val("rst_a_z", 32'(if_a.z), 0);
    check_val("rst_a_word_q", 32'(if_a.word_q), 0);
    check_val("rst_a_word_valid", 32'(if_a.word_valid), 0);
    check_val("rst_a_range_err", 32'(if_a.range_err), 0);
    check_val("rst_a_bit_idx", 32'(if_a.bit_idx), 0);
    check_val("rst_b_z", 32'(if_b.z), 0);
    check_val("rst_b_word_q", 32'(if_b.word_q), 0);
    check_val("rst_b_bit_idx", 32'(if_b.bit_idx), 0);
  endtask

  int p0;

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    model_reset();
    pulses[0] = 0; pulses[1] = 0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;

    // 1: all 16 codes, odd parity, back-to-back
    for (int v = 0; v < 16; v++) send_word4(v, 1'b1);
    // 1 again explicitly: 1010 is over range
    send_word4(10, 1'b1);
    check_val("t1_word_A", 32'(if_a.word_q), 32'hA);
    check_val("t1_range_A", 32'(if_a.range_err), 1);

    // 2: even vs odd parity on 0111
    send_word4(7, 1'b0);
    send_word4(7, 1'b1);
    check_val("t2_word_7", 32'(if_a.word_q), 32'h7);

    // 3: stalls of 3 cycles between bits of 1,0,0,1
    p0 = pulses[0];
    cycle(1'b0, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      cycle(bit'(i == 0 || i == 3), 1'b1, 1'b0, 1'b1);
      if (i < 3) for (int s = 0; s < 3; s++) cycle(bit'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b1);
    end
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    check_val("t3_word_9", 32'(if_a.word_q), 32'h9);
    check_val("t3_pulses", 32'(pulses[0] - p0), 1);

    // 4: async reset mid-word, then 0111; then sync_clr at bit 3
    cycle(1'b1, 1'b1, 1'b0, 1'b1);
    cycle(1'b1, 1'b1, 1'b0, 1'b1);
    @(posedge clk);
    #3;
    drive(1'b1, 1'b1, 1'b0, 1'b1);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_reset_outputs();
    @(posedge clk);
    #1;
    check_reset_outputs();
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    rst_n = 1'b1;
    send_word4(7, 1'b1);
    check_val("t4_word_7", 32'(if_a.word_q), 32'h7);
    cycle(1'b0, 1'b1, 1'b0, 1'b1);
    cycle(1'b1, 1'b1, 1'b0, 1'b1);
    cycle(1'b1, 1'b1, 1'b0, 1'b1);
    cycle(1'b1, 1'b1, 1'b1, 1'b1);
    check_val("t4_clr_idx", 32'(if_a.bit_idx), 0);
    check_val("t4_clr_word", 32'(if_a.word_q), 32'h7);
    check_val("t4_clr_wv", 32'(if_a.word_valid), 0);

    // 5: 8-bit LSB-first word 0x01, then 8 continuous words
    cycle(1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) cycle(bit'(i == 0), 1'b1, 1'b0, 1'b1);
    check_val("t5_word_01", 32'(if_b.word_q), 32'h01);
    check_val("t5_range", 32'(if_b.range_err), 0);
    p0 = pulses[1];
    for (int i = 0; i < 64; i++) cycle(bit'($urandom_range(0, 1)), 1'b1, 1'b0, bit'($urandom_range(0, 1)));
    check_val("t5_pulses", 32'(pulses[1] - p0), 8);

    // Random traffic with stalls, restarts and parity-mode changes
    for (int i = 0; i < 600; i++)
      cycle(bit'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 19) == 0), bit'($urandom_range(0, 1)));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
